atm_cash_dispense_ctrl: RTL and testbench
=========================================

// Module: atm_cash_dispense_ctrl
// PURPOSE
//  Sequences the note dispenser of the ATM. Accepts a withdrawal amount from the
//  session FSM and splits it into 200000/100000/50000 notes, greedy, largest first.
//  Issues one dispense command per note to the mechanism and waits for its ack.
//  Tracks the note count of each cassette and reports done/error back to the session.
// PARAMETERS
//  AMT_W        4   request width; amount in units of 50000 (max 15 = 750000)
//  CNT_W        8   cassette note-count width
//  ACK_TIMEOUT  16  cycles allowed in WAIT for disp_ack before timeout error
// PORTS
//  clock       in   1      single system clock, rising edge
//  reset       in   1      asynchronous, active-high
//  req_valid   in   1      withdrawal request
//  req_amount  in   AMT_W  amount in 50000 units
//  req_ready   out  1      high iff state==IDLE; request accepted on valid&&ready
//  load_en     in   1      cassette refill strobe, honoured only in IDLE
//  load_sel    in   2      0=50k, 1=100k, 2=200k, 3=ignored
//  load_count  in   CNT_W  new count; overwrites the selected cassette
//  disp_fire   out  1      one-cycle pulse: dispense one note
//  disp_sel    out  2      denomination of current note (0/1/2 as load_sel)
//  disp_ack    in   1      mechanism confirms one note delivered
//  busy        out  1      state != IDLE
//  done        out  1      one-cycle pulse: request completed
//  err         out  1      one-cycle pulse: request aborted
//  err_code    out  2      1=insufficient notes, 2=ack timeout, 3=zero amount; held until next accept
//  cnt_50/cnt_100/cnt_200  out  CNT_W  current cassette counts
// BEHAVIOUR
//  Reset: state IDLE. Plan and timer cleared. All counts 0. disp_fire, disp_sel, done,
//   err and err_code are 0. req_ready=1 and busy=0 once in IDLE.
//   A reset during any state aborts the request. No done or err pulse is produced.
//  States: IDLE -> PLAN -> (FIRE <-> WAIT)* -> DONE -> IDLE; PLAN/WAIT -> ERR -> IDLE.
//  IDLE: on load_en, the count is written at the edge. On valid&&ready, amount is latched
//   and the state moves to PLAN. If load and accept happen in the same cycle, both take
//   effect and PLAN sees the new count.
//  PLAN (1 cycle): a = amount.
//   n200 = min(a>>2, cnt_200); r = a - 4*n200
//   n100 = min(r>>1, cnt_100); n50 = r - 2*n100
//   a==0 -> ERR code 3. n50 > cnt_50 -> ERR code 1. No notes issued and counts unchanged
//   in both cases. Otherwise go to FIRE.
//  FIRE (1 cycle): disp_fire=1. disp_sel is 2 while n200>0, else 1 while n100>0, else 0.
//   Next state WAIT, with the timer cleared.
//  WAIT: disp_sel holds. disp_ack decrements the selected cassette count and its plan
//   count. Next state is FIRE if notes remain, else DONE.
//   The timer counts each WAIT cycle without ack. After ACK_TIMEOUT such cycles -> ERR code 2.
//   If ack arrives on the limit cycle, ack wins.
//   Counts keep the notes acked before the timeout; the unacked note is not decremented.
//  disp_ack outside WAIT is ignored. Ack in the FIRE cycle is ignored.
//  DONE / ERR (1 cycle each): pulse done or err, then IDLE. req_valid there is not accepted.
//  Latency: accept edge -> PLAN -> first disp_fire 2 cycles after accept.
//   Last ack -> done 1 cycle later.
//  load_en while busy is dropped; it is not queued. Counts never underflow,
//   because the plan is bounded by the counts.
//  Arithmetic: counts are unsigned CNT_W. Plan counters are AMT_W wide. Amount is never
//   split across denominations outside the rules above.
// TESTING
//  1 Load 10/10/10, req 7 -> fire sel 2,1,0, ack each 3 cycles later; done; counts 9/9/9.
//  2 Load 200k=0, 100k=0, 50k=2; req 3 -> err code 1, no disp_fire, counts unchanged.
//  3 Load 200k=0, 100k=5, 50k=5; req 4 -> two fires sel 1, done; cnt_100=3, cnt_50=5.
//  4 Req 2 with 100k=1, never ack -> err code 2 exactly 16 WAIT cycles after fire;
//    cnt_100 still 1. Variant with ack on the 16th cycle -> done.
//  5 Assert reset mid-WAIT -> all outputs 0 and counts 0 immediately (async).
//    Next request is accepted normally.
//  6 Req 0 -> err code 3. load_en while busy -> count unchanged.
//    Load and req together in IDLE -> plan uses the new count.

Source files
------------

// File: rtl/atm_cash_dispense_ctrl.sv
// ATM note dispenser sequencer: splits a withdrawal greedily into 200k/100k/50k notes,
// issues one dispense per note, waits for the mechanism ack and tracks cassette counts.
module atm_cash_dispense_ctrl #(
  parameter int AMT_W       = 4,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  input  logic [AMT_W-1:0] req_amount_i,
  output logic             req_ready_o,
  input  logic             load_en_i,
  input  logic [1:0]       load_sel_i,
  input  logic [CNT_W-1:0] load_count_i,
  output logic             disp_fire_o,
  output logic [1:0]       disp_sel_o,
  input  logic             disp_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] cnt_50_o,
  output logic [CNT_W-1:0] cnt_100_o,
  output logic [CNT_W-1:0] cnt_200_o
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int W     = (CNT_W > AMT_W) ? CNT_W : AMT_W;

  typedef enum logic [2:0] {S_IDLE, S_PLAN, S_FIRE, S_WAIT, S_DONE, S_ERR} state_e;

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   amount_q, amount_d;
  logic [AMT_W-1:0]   n200_q, n200_d, n100_q, n100_d, n50_q, n50_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [CNT_W-1:0]   cnt_q [3];
  logic [CNT_W-1:0]   cnt_d [3];

  logic [AMT_W-1:0]   q200_c, q100_c, n200_c, n100_c, r_c, n50_c;
  logic               short_c, last_note_c;
  logic [1:0]         sel_c;

  // Greedy split bounded by what each cassette actually holds
  assign q200_c  = amount_q >> 2;
  assign n200_c  = (W'(q200_c) <= W'(cnt_q[2])) ? q200_c : AMT_W'(cnt_q[2]);
  assign r_c     = amount_q - (n200_c << 2);
  assign q100_c  = r_c >> 1;
  assign n100_c  = (W'(q100_c) <= W'(cnt_q[1])) ? q100_c : AMT_W'(cnt_q[1]);
  assign n50_c   = r_c - (n100_c << 1);
  assign short_c = W'(n50_c) > W'(cnt_q[0]);

  assign sel_c       = (n200_q != '0) ? 2'd2 : ((n100_q != '0) ? 2'd1 : 2'd0);
  assign last_note_c = (n200_q + n100_q + n50_q) == AMT_W'(1);

  always_comb begin
    state_d    = state_q;
    amount_d   = amount_q;
    n200_d     = n200_q;
    n100_d     = n100_q;
    n50_d      = n50_q;
    timer_d    = timer_q;
    err_code_d = err_code_q;
    for (int k = 0; k < 3; k++) cnt_d[k] = cnt_q[k];

    case (state_q)
      S_IDLE: begin
        if (load_en_i) begin
          for (int k = 0; k < 3; k++)
            if (load_sel_i == 2'(k)) cnt_d[k] = load_count_i;
        end
        if (req_valid_i) begin
          amount_d   = req_amount_i;
          err_code_d = 2'd0;
          state_d    = S_PLAN;
        end
      end
      S_PLAN: begin
        if (amount_q == '0) begin
          err_code_d = 2'd3;
          state_d    = S_ERR;
        end else if (short_c) begin
          err_code_d = 2'd1;
          state_d    = S_ERR;
        end else begin
          n200_d  = n200_c;
          n100_d  = n100_c;
          n50_d   = n50_c;
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack on the limit cycle still counts as delivered
        if (disp_ack_i) begin
          for (int k = 0; k < 3; k++)
            if (sel_c == 2'(k)) cnt_d[k] = cnt_q[k] - CNT_W'(1);
          case (sel_c)
            2'd2:    n200_d = n200_q - AMT_W'(1);
            2'd1:    n100_d = n100_q - AMT_W'(1);
            default: n50_d  = n50_q - AMT_W'(1);
          endcase
          state_d = last_note_c ? S_DONE : S_FIRE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          err_code_d = 2'd2;
          state_d    = S_ERR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      amount_q   <= '0;
      n200_q     <= '0;
      n100_q     <= '0;
      n50_q      <= '0;
      timer_q    <= '0;
      err_code_q <= 2'd0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      amount_q   <= amount_d;
      n200_q     <= n200_d;
      n100_q     <= n100_d;
      n50_q      <= n50_d;
      timer_q    <= timer_d;
      err_code_q <= err_code_d;
      for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign disp_fire_o = (state_q == S_FIRE);
  assign disp_sel_o  = ((state_q == S_FIRE) || (state_q == S_WAIT)) ? sel_c : 2'd0;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_ERR);
  assign err_code_o  = err_code_q;
  assign cnt_50_o    = cnt_q[0];
  assign cnt_100_o   = cnt_q[1];
  assign cnt_200_o   = cnt_q[2];

endmodule

// File: tb/tb_atm_cash_dispense_ctrl.sv
// Bench for atm_cash_dispense_ctrl: vector table of withdrawals with a note/outcome
// scoreboard, plus sequences for reset mid-dispense, busy loads and load+request.
module tb_atm_cash_dispense_ctrl;

  logic       clk = 0;
  logic       rst = 1;
  logic       req_valid = 0;
  logic [3:0] req_amount = 0;
  logic       req_ready;
  logic       load_en = 0;
  logic [1:0] load_sel = 0;
  logic [7:0] load_count = 0;
  logic       disp_fire;
  logic [1:0] disp_sel;
  logic       disp_ack = 0;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic [7:0] cnt_50, cnt_100, cnt_200;

  atm_cash_dispense_ctrl #(.AMT_W(4), .CNT_W(8), .ACK_TIMEOUT(16)) dut (
    .clock_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_amount_i(req_amount), .req_ready_o(req_ready),
    .load_en_i(load_en), .load_sel_i(load_sel), .load_count_i(load_count),
    .disp_fire_o(disp_fire), .disp_sel_o(disp_sel), .disp_ack_i(disp_ack),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code),
    .cnt_50_o(cnt_50), .cnt_100_o(cnt_100), .cnt_200_o(cnt_200)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c50, c100, c200, amt, dly, nf;
    logic [15:0] sels;
    bit is_err; int code;
    int e50, e100, e200, gap;
  } vec_t;

  typedef struct { bit is_err; int code; int gap; } outc_t;

  vec_t  vecs[10];
  int    fire_q[$];
  outc_t outc_q[$];

  int tests = 0, fails = 0;
  int cyc = 0;
  int ack_delay = 0;
  int outcomes_seen = 0;
  int accept_cyc = 0, fire_cyc = 0, last_ack_cyc = 0;
  bit first_fire_pending = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(int c50, int c100, int c200, int amt, int dly, int nf,
                              int sels, bit is_err, int code, int e50, int e100,
                              int e200, int gap);
    vec_t v;
    v.c50 = c50; v.c100 = c100; v.c200 = c200; v.amt = amt; v.dly = dly; v.nf = nf;
    v.sels = 16'(sels); v.is_err = is_err; v.code = code;
    v.e50 = e50; v.e100 = e100; v.e200 = e200; v.gap = gap;
    return v;
  endfunction

  // Mechanism model: ack each note ack_delay cycles after its fire (0 = never)
  initial forever begin
    @(negedge clk);
    if (!rst && disp_fire && ack_delay != 0) begin
      repeat (ack_delay) @(posedge clk);
      #1 disp_ack = 1;
      @(posedge clk);
      #1 disp_ack = 0;
    end
  end

  // Output monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (req_valid && req_ready) accept_cyc = cyc;
      if (disp_ack) last_ack_cyc = cyc;
      if (disp_fire) begin
        if (fire_q.size() == 0) check("fire_unexpected", 1, 0);
        else check("fire_sel", disp_sel, fire_q.pop_front());
        if (first_fire_pending) check("first_fire_latency", cyc - accept_cyc, 2);
        first_fire_pending = 0;
        fire_cyc = cyc;
      end
      if (done || err) begin
        if (outc_q.size() == 0) check("outcome_unexpected", 1, 0);
        else begin
          outc_t o;
          o = outc_q.pop_front();
          check("outcome_err", err, o.is_err);
          check("outcome_done", done, !o.is_err);
          if (o.is_err) check("err_code", err_code, o.code);
          else check("done_after_ack", cyc - last_ack_cyc, 1);
          if (o.gap != 0) check("timeout_gap", cyc - fire_cyc, o.gap);
        end
        outcomes_seen++;
      end
    end
  end

  task automatic load(input int sel, input int cnt);
    load_en = 1; load_sel = 2'(sel); load_count = 8'(cnt);
    @(posedge clk); #1;
    load_en = 0;
  endtask

  task automatic expect_req(input vec_t v);
    for (int i = 0; i < v.nf; i++) fire_q.push_back(int'(v.sels[2*i +: 2]));
    outc_q.push_back('{v.is_err, v.code, v.gap});
    first_fire_pending = (v.nf > 0);
    ack_delay = v.dly;
  endtask

  task automatic wait_outcome(input int n0);
    for (int i = 0; i < 400 && outcomes_seen == n0; i++) begin
      @(posedge clk); #1;
    end
    check("outcome_seen", int'(outcomes_seen > n0), 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n0;
    load(0, v.c50); load(1, v.c100); load(2, v.c200);
    expect_req(v);
    n0 = outcomes_seen;
    req_valid = 1; req_amount = 4'(v.amt);
    @(posedge clk); #1;
    req_valid = 0;
    wait_outcome(n0);
    check("cnt_50", cnt_50, v.e50);
    check("cnt_100", cnt_100, v.e100);
    check("cnt_200", cnt_200, v.e200);
    check("fires_missing", fire_q.size(), 0);
    $display("[TB] vec %0d amt=%0d -> %s code=%0d counts %0d/%0d/%0d", idx, v.amt,
             v.is_err ? "err" : "done", err_code, cnt_50, cnt_100, cnt_200);
  endtask

  initial begin
    int n0;
    vecs[0] = mk(10, 10, 10,  7, 3, 3,   6, 0, 0, 9, 9, 9, 0);
    vecs[1] = mk( 2,  0,  0,  3, 3, 0,   0, 1, 1, 2, 0, 0, 0);
    vecs[2] = mk( 5,  5,  0,  4, 2, 2,   5, 0, 0, 5, 3, 0, 0);
    vecs[3] = mk( 0,  1,  0,  2, 0, 1,   1, 1, 2, 0, 1, 0, 17);
    vecs[4] = mk( 0,  1,  0,  2,16, 1,   1, 0, 0, 0, 0, 0, 0);
    vecs[5] = mk( 3,  3,  3,  0, 3, 0,   0, 1, 3, 3, 3, 3, 0);
    vecs[6] = mk( 1,  1,  1, 15, 3, 0,   0, 1, 1, 1, 1, 1, 0);
    vecs[7] = mk(10, 10, 10, 15, 1, 5, 106, 0, 0, 9, 9, 7, 0);
    vecs[8] = mk( 1,  2,  0,  5, 2, 3,   5, 0, 0, 0, 0, 0, 0);
    vecs[9] = mk( 0,  5,  5,  1, 3, 0,   0, 1, 1, 0, 5, 5, 0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fire", disp_fire, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_err_code", err_code, 0);
    check("rst_counts", {cnt_50, cnt_100, cnt_200}, 0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of a WAIT
    load(0, 10); load(1, 10); load(2, 10);
    fire_q.push_back(1);
    first_fire_pending = 1;
    ack_delay = 0;
    req_valid = 1; req_amount = 4'd2;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1;
    check("arst_fire_sel", {disp_fire, disp_sel}, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", req_ready, 1);
    check("arst_done_err_code", {done, err, err_code}, 0);
    check("arst_counts", {cnt_50, cnt_100, cnt_200}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    check("arst_no_stray_fire", fire_q.size(), 0);
    $display("[TB] reset mid-WAIT: outputs and counts cleared");
    run_vec(10, vecs[0]);

    // Load while busy is dropped
    load(0, 10); load(1, 10); load(2, 10);
    fire_q.push_back(0);
    outc_q.push_back('{0, 0, 0});
    first_fire_pending = 1;
    ack_delay = 5;
    n0 = outcomes_seen;
    req_valid = 1; req_amount = 4'd1;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (2) @(posedge clk);
    #1 load(0, 99);
    wait_outcome(n0);
    check("busy_load_cnt_50", cnt_50, 9);
    $display("[TB] load while busy: cnt_50=%0d", cnt_50);

    // Load and request in the same IDLE cycle: plan sees new count
    load(0, 0); load(1, 0); load(2, 0);
    fire_q.push_back(0); fire_q.push_back(0); fire_q.push_back(0);
    outc_q.push_back('{0, 0, 0});
    first_fire_pending = 1;
    ack_delay = 2;
    n0 = outcomes_seen;
    load_en = 1; load_sel = 2'd0; load_count = 8'd3;
    req_valid = 1; req_amount = 4'd3;
    @(posedge clk); #1;
    load_en = 0; req_valid = 0;
    wait_outcome(n0);
    check("same_cycle_cnt_50", cnt_50, 0);
    check("same_cycle_fires", fire_q.size(), 0);
    $display("[TB] load+req same cycle: cnt_50=%0d", cnt_50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
